// File: rtl/fft_mem_sequencer_pkg.sv
// Shared types and helpers for the FFT memory sequencer: FSM state
// encoding, counter-width helpers and the bit-reversal function.
package fft_mem_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Bits needed to hold a stage index 0..addr_width-1.
  function automatic int stage_width(input int addr_width);
    return (addr_width > 1) ? $clog2(addr_width) : 1;
  endfunction

  // Bits needed to hold a wait count 0..latency-1.
  function automatic int wait_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

  // Reverse the low 'width' bits of 'value'; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r[i] = value[width - 1 - i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_mem_sequencer_bfly_addr.sv
// Radix-2 DIT in-place addressing: maps (stage, butterfly index) to the
// two RAM addresses of the pair and the twiddle ROM index.
module fft_mem_sequencer_bfly_addr #(
  parameter int ADDR_WIDTH = 5,
  parameter int STAGE_W    = 3
) (
  input  logic [STAGE_W-1:0]    i_stage,
  input  logic [ADDR_WIDTH-2:0] i_bfly,
  output logic [ADDR_WIDTH-1:0] o_a_addr,
  output logic [ADDR_WIDTH-1:0] o_b_addr,
  output logic [ADDR_WIDTH-2:0] o_tw_idx
);

  // Double-width intermediates so the twiddle shift never loses bits.
  localparam int WW = 2 * ADDR_WIDTH;

  logic [WW-1:0] w_j;
  logic [WW-1:0] w_half;
  logic [WW-1:0] w_pos;
  logic [WW-1:0] w_grp;
  logic [WW-1:0] w_a;
  logic [WW-1:0] w_b;
  logic [WW-1:0] w_tw;

  // Split j into position-in-group and group, then interleave around bit s.
  always_comb begin
    w_j      = WW'(i_bfly);
    w_half   = WW'(1) << i_stage;
    w_pos    = w_j & (w_half - WW'(1));
    w_grp    = w_j >> i_stage;
    w_a      = ((w_grp << i_stage) << 1) | w_pos;
    w_b      = w_a + w_half;
    w_tw     = (w_pos << (ADDR_WIDTH - 1)) >> i_stage;
    o_a_addr = w_a[ADDR_WIDTH-1:0];
    o_b_addr = w_b[ADDR_WIDTH-1:0];
    o_tw_idx = w_tw[ADDR_WIDTH-2:0];
  end

endmodule

// File: rtl/fft_mem_sequencer.sv
// Control/address sequencer for the dual-port FFT sample RAM: bit-reversed
// load of N samples, then the in-place radix-2 DIT butterfly schedule.
module fft_mem_sequencer
  import fft_mem_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int BFLY_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_sample_valid,
  output logic                  o_sample_ready,
  output logic                  o_singlewrite,
  output logic                  o_row,
  output logic [ADDR_WIDTH-1:0] o_a_addr,
  output logic [ADDR_WIDTH-1:0] o_b_addr,
  output logic [ADDR_WIDTH-2:0] o_tw_idx,
  output logic                  o_bfly_en,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int STAGE_W = stage_width(ADDR_WIDTH);
  localparam int WAIT_W  = wait_width(BFLY_LATENCY);

  localparam logic [ADDR_WIDTH-1:0] LOAD_LAST  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-2:0] BFLY_LAST  = {(ADDR_WIDTH-1){1'b1}};
  localparam logic [STAGE_W-1:0]    STAGE_LAST = STAGE_W'(ADDR_WIDTH - 1);
  localparam logic [WAIT_W-1:0]     WAIT_LAST  = WAIT_W'(BFLY_LATENCY - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_load_cnt;
  logic [STAGE_W-1:0]      r_stage;
  logic [ADDR_WIDTH-2:0]   r_bfly;
  logic [WAIT_W-1:0]       r_wait;

  logic                    w_load_accept;
  logic                    w_load_last;
  logic                    w_wait_last;
  logic                    w_bfly_last;
  logic                    w_stage_last;
  logic [ADDR_WIDTH-1:0]   w_load_addr;
  logic [ADDR_WIDTH-1:0]   w_pair_a;
  logic [ADDR_WIDTH-1:0]   w_pair_b;
  logic [ADDR_WIDTH-2:0]   w_pair_tw;

  assign w_load_accept = (r_state == ST_LOAD) && i_sample_valid;
  assign w_load_last   = w_load_accept && (r_load_cnt == LOAD_LAST);
  assign w_wait_last   = (r_wait == WAIT_LAST);
  assign w_bfly_last   = (r_bfly == BFLY_LAST);
  assign w_stage_last  = (r_stage == STAGE_LAST);
  assign w_load_addr   = ADDR_WIDTH'(bitrev(32'(r_load_cnt), ADDR_WIDTH));

  fft_mem_sequencer_bfly_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STAGE_W    (STAGE_W)
  ) u_bfly_addr (
    .i_stage  (r_stage),
    .i_bfly   (r_bfly),
    .o_a_addr (w_pair_a),
    .o_b_addr (w_pair_b),
    .o_tw_idx (w_pair_tw)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_load_last) begin
          w_state_nxt = ST_READ;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_READ: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_wait_last) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WRITE: begin
        if (w_bfly_last && w_stage_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_READ;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Load, stage, butterfly and wait counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_load_cnt <= '0;
      r_stage    <= '0;
      r_bfly     <= '0;
      r_wait     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_load_cnt <= '0;
          r_stage    <= '0;
          r_bfly     <= '0;
          r_wait     <= '0;
        end
        ST_LOAD: begin
          if (w_load_accept) begin
            r_load_cnt <= r_load_cnt + ADDR_WIDTH'(1);
          end
          r_stage <= '0;
          r_bfly  <= '0;
          r_wait  <= '0;
        end
        ST_READ: begin
          r_wait <= '0;
        end
        ST_WAIT: begin
          if (w_wait_last) begin
            r_wait <= '0;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_WRITE: begin
          r_bfly <= r_bfly + (ADDR_WIDTH-1)'(1);
          if (w_bfly_last) begin
            if (w_stage_last) begin
              r_stage <= '0;
            end else begin
              r_stage <= r_stage + STAGE_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_load_cnt <= '0;
          r_stage    <= '0;
          r_bfly     <= '0;
          r_wait     <= '0;
        end
        default: begin
          r_load_cnt <= '0;
          r_stage    <= '0;
          r_bfly     <= '0;
          r_wait     <= '0;
        end
      endcase
    end
  end

  // Output decode from the registered state and counters.
  always_comb begin
    o_sample_ready = 1'b0;
    o_singlewrite  = 1'b0;
    o_row          = 1'b0;
    o_a_addr       = '0;
    o_b_addr       = '0;
    o_tw_idx       = '0;
    o_bfly_en      = 1'b0;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
      end
      ST_LOAD: begin
        o_busy         = 1'b1;
        o_sample_ready = 1'b1;
        o_singlewrite  = i_sample_valid;
        o_a_addr       = w_load_addr;
      end
      ST_READ: begin
        o_busy   = 1'b1;
        o_a_addr = w_pair_a;
        o_b_addr = w_pair_b;
        o_tw_idx = w_pair_tw;
      end
      ST_WAIT: begin
        o_busy    = 1'b1;
        o_a_addr  = w_pair_a;
        o_b_addr  = w_pair_b;
        o_tw_idx  = w_pair_tw;
        o_bfly_en = (r_wait == WAIT_W'(0));
      end
      ST_WRITE: begin
        o_busy   = 1'b1;
        o_row    = 1'b1;
        o_a_addr = w_pair_a;
        o_b_addr = w_pair_b;
        o_tw_idx = w_pair_tw;
      end
      ST_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fft_mem_sequencer.sv
// Self-checking bench for fft_mem_sequencer (N=32). A transform-level model
// predicts every output each cycle; literal checks pin key addresses/timing.
module tb_fft_mem_sequencer;

  localparam int AW    = 5;
  localparam int N     = 32;
  localparam int HALFN = 16;
  localparam int LAT   = 2;
  localparam int P     = LAT + 2;
  localparam int TOTAL = AW * HALFN * P;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, valid;
  logic sready, swr, row, bfen, busy, done;
  logic [AW-1:0] a_addr, b_addr;
  logic [AW-2:0] tw;

  logic rst1, start1, valid1;
  logic sready1, swr1, row1, bfen1, busy1, done1;
  logic [AW-1:0] a1, b1;
  logic [AW-2:0] tw1;

  fft_mem_sequencer #(.ADDR_WIDTH(AW), .BFLY_LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sample_valid(valid),
    .o_sample_ready(sready), .o_singlewrite(swr), .o_row(row),
    .o_a_addr(a_addr), .o_b_addr(b_addr), .o_tw_idx(tw),
    .o_bfly_en(bfen), .o_busy(busy), .o_done(done)
  );

  fft_mem_sequencer #(.ADDR_WIDTH(AW), .BFLY_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_sample_valid(valid1),
    .o_sample_ready(sready1), .o_singlewrite(swr1), .o_row(row1),
    .o_a_addr(a1), .o_b_addr(b1), .o_tw_idx(tw1),
    .o_bfly_en(bfen1), .o_busy(busy1), .o_done(done1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic int brev(input int v);
    int r = 0;
    for (int k = 0; k < AW; k++) r = (r << 1) | ((v >> k) & 1);
    return r;
  endfunction

  // ---------------- transform-level model ----------------
  int mode = M_IDLE;
  int ld = 0;
  int t = 0;
  int cyc = 0;
  int last_load_cyc = 0;
  bit started = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    started = 1'b1;
    if (rst) begin
      mode = M_IDLE; ld = 0; t = 0;
    end else begin
      case (mode)
        M_IDLE: if (start) begin mode = M_LOAD; ld = 0; end
        M_LOAD: if (valid) begin
          if (ld == N - 1) begin mode = M_RUN; t = 0; last_load_cyc = cyc - 1; end
          else ld = ld + 1;
        end
        M_RUN:  if (t == TOTAL - 1) mode = M_DONE; else t = t + 1;
        default: mode = M_IDLE;
      endcase
    end
  end

  // ---------------- per-cycle compare + scoreboards ----------------
  int ld_q[$];
  int wr_cnt = 0;
  int be_cnt = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    logic [19:0] got_v, exp_v;
    int b, ph, s, j, half, pos, grp, ea, eb, et;
    if (started) begin
      exp_v = 20'd0;
      if (mode == M_LOAD) begin
        exp_v[19] = 1'b1;
        exp_v[18] = valid;
        exp_v[16:12] = AW'(brev(ld));
        exp_v[1] = 1'b1;
      end else if (mode == M_RUN) begin
        b = t / P; ph = t % P;
        s = b / HALFN; j = b % HALFN;
        half = 1 << s; pos = j % half; grp = j / half;
        ea = grp * 2 * half + pos; eb = ea + half; et = pos * HALFN / half;
        exp_v[17] = (ph == P - 1);
        exp_v[16:12] = AW'(ea);
        exp_v[11:7] = AW'(eb);
        exp_v[6:3] = 4'(et);
        exp_v[2] = (ph == 1);
        exp_v[1] = 1'b1;
        if (ph == 0 && b == 3)  chk("s0_j3_pair",  {a_addr, b_addr, tw}, {5'd6, 5'd7, 4'd0});
        if (ph == 0 && b == 37) chk("s2_j5_pair",  {a_addr, b_addr, tw}, {5'd9, 5'd13, 4'd4});
        if (ph == 0 && b == 79) chk("s4_j15_pair", {a_addr, b_addr, tw}, {5'd15, 5'd31, 4'd15});
      end else if (mode == M_DONE) begin
        exp_v[1] = 1'b1;
        exp_v[0] = 1'b1;
      end
      got_v = {sready, swr, row, a_addr, b_addr, tw, bfen, busy, done};
      chk("cycle_outputs", 64'(got_v), 64'(exp_v));
      if (swr) ld_q.push_back(int'(a_addr));
      if (row) wr_cnt++;
      if (bfen) be_cnt++;
      if (done) done_cyc = cyc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  int lit8[8] = '{0, 16, 8, 24, 4, 20, 12, 28};

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; valid1 = 1'b0;
    repeat (3) tick;
    rst = 1'b0; rst1 = 1'b0;
    tick;
    @(negedge clk);
    chk("reset_outputs", {sready, swr, row, a_addr, b_addr, tw, bfen, busy, done}, 64'd0);

    // 1: reset held mid-LOAD
    tick;
    start = 1'b1; tick; start = 1'b0;
    valid = 1'b1; repeat (5) tick;
    rst = 1'b1; repeat (3) tick;
    @(negedge clk);
    chk("rst_mid_load", {sready, swr, row, a_addr, b_addr, tw, bfen, busy, done}, 64'd0);
    rst = 1'b0; valid = 1'b0;
    tick;

    // 2: back-to-back load, full run, start ignored in WAIT and DONE
    ld_q.delete(); wr_cnt = 0; be_cnt = 0;
    start = 1'b1; tick; start = 1'b0;
    valid = 1'b1; repeat (N) tick; valid = 1'b0;
    @(negedge clk);
    chk("ready_after_load", sready, 1'b0);
    chk("load_write_count", ld_q.size(), N);
    for (int i = 0; i < 8; i++) chk("load_addr_lit", ld_q[i], lit8[i]);
    for (int i = 0; i < N; i++) chk("load_addr_bitrev", ld_q[i], brev(i));
    tick;                       // now in first WAIT
    start = 1'b1; tick; start = 1'b0;
    wait_done("run1");
    start = 1'b1;               // present in DONE cycle only
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("start_in_done_ignored", {busy, sready}, 2'b00);
    chk("done_latency", done_cyc - last_load_cyc, 321);
    chk("write_pairs", wr_cnt, 80);
    chk("bfly_en_count", be_cnt, 80);
    tick;

    // 3: stalled load, then reset in stage 3 and a fresh load
    ld_q.delete();
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      valid = (i % 2 == 0); tick;
    end
    valid = 1'b0;
    chk("stall_write_count", ld_q.size(), N);
    for (int i = 0; i < N; i++) chk("stall_addr_bitrev", ld_q[i], brev(i));
    for (int i = 0; i < 400 && !(mode == M_RUN && t >= 3 * HALFN * P + 20); i++) tick;
    chk("reached_stage3", (mode == M_RUN) && (t / P / HALFN == 3), 1'b1);
    rst = 1'b1; repeat (2) tick; rst = 1'b0;
    tick;
    @(negedge clk);
    chk("busy_after_rst", busy, 1'b0);
    ld_q.delete();
    start = 1'b1; tick; start = 1'b0;
    valid = 1'b1; repeat (2) tick; valid = 1'b0;
    chk("fresh_load_len", ld_q.size(), 2);
    if (ld_q.size() == 2) chk("fresh_load_addrs", {ld_q[0][4:0], ld_q[1][4:0]}, {5'd0, 5'd16});
    valid = 1'b1; repeat (N - 2) tick; valid = 1'b0;
    wait_done("run2");
    tick;

    // 5b: latency-1 instance timing
    begin
      int k = 0;
      bit seen = 1'b0;
      start1 = 1'b1; tick; start1 = 1'b0;
      valid1 = 1'b1; repeat (N) tick; valid1 = 1'b0;
      for (int i = 1; i <= 600 && !seen; i++) begin
        @(negedge clk);
        if (done1) begin seen = 1'b1; k = i; end
        else begin @(posedge clk); #1; end
      end
      chk("lat1_done_latency", k, 241);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
